decode_control_unit: RTL and testbench
======================================

DECODE_CONTROL_UNIT -- requirements
Module: decode_control_unit

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 instruction  in  32  instruction in Decode.
REQ-006 zeroSignal  in  1  1 = forwarded CBZ operand is zero.
REQ-007 negativeEX, zeroEX, overflowEX, carryEX  in  1 each  ALU flags of the instruction in EX.
REQ-008 setFlag_EX  in  1  instruction in EX sets flags.
REQ-009 Reg2Loc  out  1  1 = read Rm, 0 = read Rd; ALUSrc  out  2  00 reg, 01 Imm9, 10 Imm12.
REQ-010 MemToReg, RegWrite, MemWrite, BrTaken, UncondBr, UseShift, shiftRight, setFlag  out  1 each.
REQ-011 ALUOp  out  3  000 passB, 010 add, 011 sub, 100 and, 110 xor.
REQ-012 condAddr19Extended, brAddr26Extended  out  64  sign-extended branch offsets, unshifted.
REQ-013 negativeFlag, zeroFlag, overflowFlag, carryFlag  out  1 each  flag register contents.

Function
REQ-014 condAddr19Extended SHALL be instruction[23:5] sign-extended from bit 23; brAddr26Extended SHALL be instruction[25:0] sign-extended from bit 25; both combinational.
REQ-015 Decode SHALL match: ADDI [31:22]=1001000100; B [31:26]=000101; CBZ [31:24]=10110100; B.cond [31:24]=01010100 with [4:0]=01011 (LT); 11-bit [31:21]: ADDS 10101011000, SUBS 11101011000, AND 10001010000, EOR 11001010000, LDUR 11111000010, STUR 11111000000, LSR 11010011010, LSL 11010011011.
REQ-016 Every output not listed for an instruction SHALL be 0.
REQ-017 ADDI: RegWrite=1, ALUSrc=10, ALUOp=010.
REQ-018 ADDS/SUBS: Reg2Loc=1, RegWrite=1, setFlag=1, ALUOp=010/011.
REQ-019 AND/EOR: Reg2Loc=1, RegWrite=1, ALUOp=100/110.
REQ-020 LSL/LSR: RegWrite=1, UseShift=1, shiftRight=1 for LSR only.
REQ-021 LDUR: ALUSrc=01, MemToReg=1, RegWrite=1, ALUOp=010.
REQ-022 STUR: Reg2Loc=0, ALUSrc=01, MemWrite=1, ALUOp=010.
REQ-023 B: BrTaken=1, UncondBr=1.
REQ-024 CBZ: Reg2Loc=0, ALUOp=000, BrTaken=zeroSignal.
REQ-025 B.LT: BrTaken = N XOR V, where N,V = negativeEX,overflowEX when setFlag_EX=1, else negativeFlag,overflowFlag (forwarding).
REQ-026 B.cond with any other cond field and any undecoded instruction SHALL produce all-zero control (NOP).
REQ-027 Control outputs SHALL be purely combinational (zero latency).
REQ-028 Flag register SHALL load all four EX flags on rising clk when setFlag_EX=1 and hold otherwise.
REQ-029 A flag load and a B.LT decode in the same cycle SHALL use the EX values (REQ-025), not the old register.

Reset
REQ-030 reset=1 SHALL clear all four flags immediately (asynchronously) and hold them at 0 while asserted.
REQ-031 While reset=1, RegWrite, MemWrite, BrTaken and setFlag SHALL be forced to 0; extenders unaffected.
REQ-032 Reset asserted mid-operation SHALL abandon any pending flag load; first load occurs on the first rising clk after deassertion.

Verification
REQ-033 Reset pulse -> all flags 0; instruction 0x00000000 -> every control output 0.
REQ-034 0x91001401 (ADDI X1,X0,#5) -> RegWrite=1, ALUSrc=10, ALUOp=010, MemWrite=0, BrTaken=0.
REQ-035 0x17FFFFFF (B -1) -> BrTaken=1, UncondBr=1, brAddr26Extended=0xFFFFFFFFFFFFFFFF.
REQ-036 0xB4000083 (CBZ X3,+4) -> condAddr19Extended=4, Reg2Loc=0; zeroSignal=1 -> BrTaken=1; zeroSignal=0 -> BrTaken=0.
REQ-037 0x5400004B (B.LT +2): setFlag_EX=1, negativeEX=1, overflowEX=0 -> BrTaken=1; after reset with setFlag_EX=0 -> BrTaken=0; after clk edge loading N=1,V=1 -> BrTaken=0.
REQ-038 0xF8000000 (STUR) -> MemWrite=1, RegWrite=0, Reg2Loc=0, ALUSrc=01; 0xF8400000 (LDUR) -> MemToReg=1, RegWrite=1, MemWrite=0.

Source files
------------

// File: rtl/decode_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : decode_control_unit
// Purpose  : Decode-stage control for a pipelined ARMv8 subset. Produces the
//            datapath control word combinationally from the instruction in
//            Decode, sign-extends the branch offsets, and holds the NZVC flag
//            register. B.LT uses the EX flags when the instruction in EX is
//            setting them, and the flag register otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module decode_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zeroSignal,
  input  logic        negativeEX,
  input  logic        zeroEX,
  input  logic        overflowEX,
  input  logic        carryEX,
  input  logic        setFlag_EX,
  output logic        Reg2Loc,
  output logic [1:0]  ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        BrTaken,
  output logic        UncondBr,
  output logic        UseShift,
  output logic        shiftRight,
  output logic        setFlag,
  output logic [2:0]  ALUOp,
  output logic [63:0] condAddr19Extended,
  output logic [63:0] brAddr26Extended,
  output logic        negativeFlag,
  output logic        zeroFlag,
  output logic        overflowFlag,
  output logic        carryFlag
);

  // Opcode patterns
  localparam logic [9:0]  c_ADDI = 10'b1001000100;
  localparam logic [5:0]  c_B    = 6'b000101;
  localparam logic [7:0]  c_CBZ  = 8'b10110100;
  localparam logic [7:0]  c_BCND = 8'b01010100;
  localparam logic [4:0]  c_LT   = 5'b01011;
  localparam logic [10:0] c_ADDS = 11'b10101011000;
  localparam logic [10:0] c_SUBS = 11'b11101011000;
  localparam logic [10:0] c_AND  = 11'b10001010000;
  localparam logic [10:0] c_EOR  = 11'b11001010000;
  localparam logic [10:0] c_LDUR = 11'b11111000010;
  localparam logic [10:0] c_STUR = 11'b11111000000;
  localparam logic [10:0] c_LSR  = 11'b11010011010;
  localparam logic [10:0] c_LSL  = 11'b11010011011;

  // ALU operation encodings
  localparam logic [2:0] c_ALU_PASSB = 3'b000;
  localparam logic [2:0] c_ALU_ADD   = 3'b010;
  localparam logic [2:0] c_ALU_SUB   = 3'b011;
  localparam logic [2:0] c_ALU_AND   = 3'b100;
  localparam logic [2:0] c_ALU_XOR   = 3'b110;

  logic r_negativeFlag;
  logic r_zeroFlag;
  logic r_overflowFlag;
  logic r_carryFlag;

  logic [10:0] w_op11;
  logic        w_ltTaken;
  logic        w_regWrite;
  logic        w_memWrite;
  logic        w_brTaken;
  logic        w_setFlag;

  assign w_op11 = instruction[31:21];

  // Branch offsets are sign-extended but left unshifted; the adder stage scales them
  assign condAddr19Extended = {{45{instruction[23]}}, instruction[23:5]};
  assign brAddr26Extended   = {{38{instruction[25]}}, instruction[25:0]};

  // Flag register: async clear, load all four EX flags when EX sets flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_negativeFlag <= 1'b0;
      r_zeroFlag     <= 1'b0;
      r_overflowFlag <= 1'b0;
      r_carryFlag    <= 1'b0;
    end else if (setFlag_EX) begin
      r_negativeFlag <= negativeEX;
      r_zeroFlag     <= zeroEX;
      r_overflowFlag <= overflowEX;
      r_carryFlag    <= carryEX;
    end
  end

  assign negativeFlag = r_negativeFlag;
  assign zeroFlag     = r_zeroFlag;
  assign overflowFlag = r_overflowFlag;
  assign carryFlag    = r_carryFlag;

  // LT condition: forward from EX when the flags there are not yet registered
  assign w_ltTaken = setFlag_EX ? (negativeEX ^ overflowEX)
                                : (r_negativeFlag ^ r_overflowFlag);

  // Main decoder: everything defaults to zero so unmatched encodings act as NOP
  always_comb begin
    Reg2Loc    = 1'b0;
    ALUSrc     = 2'b00;
    MemToReg   = 1'b0;
    w_regWrite = 1'b0;
    w_memWrite = 1'b0;
    w_brTaken  = 1'b0;
    UncondBr   = 1'b0;
    UseShift   = 1'b0;
    shiftRight = 1'b0;
    w_setFlag  = 1'b0;
    ALUOp      = c_ALU_PASSB;

    if (instruction[31:22] == c_ADDI) begin
      w_regWrite = 1'b1;
      ALUSrc     = 2'b10;
      ALUOp      = c_ALU_ADD;
    end else if (instruction[31:26] == c_B) begin
      w_brTaken  = 1'b1;
      UncondBr   = 1'b1;
    end else if (instruction[31:24] == c_CBZ) begin
      ALUOp      = c_ALU_PASSB;
      w_brTaken  = zeroSignal;
    end else if (instruction[31:24] == c_BCND) begin
      if (instruction[4:0] == c_LT) begin
        w_brTaken = w_ltTaken;
      end
    end else begin
      case (w_op11)
        c_ADDS: begin
          Reg2Loc    = 1'b1;
          w_regWrite = 1'b1;
          w_setFlag  = 1'b1;
          ALUOp      = c_ALU_ADD;
        end
        c_SUBS: begin
          Reg2Loc    = 1'b1;
          w_regWrite = 1'b1;
          w_setFlag  = 1'b1;
          ALUOp      = c_ALU_SUB;
        end
        c_AND: begin
          Reg2Loc    = 1'b1;
          w_regWrite = 1'b1;
          ALUOp      = c_ALU_AND;
        end
        c_EOR: begin
          Reg2Loc    = 1'b1;
          w_regWrite = 1'b1;
          ALUOp      = c_ALU_XOR;
        end
        c_LDUR: begin
          ALUSrc     = 2'b01;
          MemToReg   = 1'b1;
          w_regWrite = 1'b1;
          ALUOp      = c_ALU_ADD;
        end
        c_STUR: begin
          ALUSrc     = 2'b01;
          w_memWrite = 1'b1;
          ALUOp      = c_ALU_ADD;
        end
        c_LSR: begin
          w_regWrite = 1'b1;
          UseShift   = 1'b1;
          shiftRight = 1'b1;
        end
        c_LSL: begin
          w_regWrite = 1'b1;
          UseShift   = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Suppress every architectural side effect while reset is held
  assign RegWrite = w_regWrite & ~reset;
  assign MemWrite = w_memWrite & ~reset;
  assign BrTaken  = w_brTaken  & ~reset;
  assign setFlag  = w_setFlag  & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_decode_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_control_unit
// Purpose  : Directed vectors for decode_control_unit with a queue-based
//            scoreboard; expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        zeroSignal;
  logic        negativeEX, zeroEX, overflowEX, carryEX;
  logic        setFlag_EX;
  logic        Reg2Loc;
  logic [1:0]  ALUSrc;
  logic        MemToReg, RegWrite, MemWrite, BrTaken, UncondBr;
  logic        UseShift, shiftRight, setFlag;
  logic [2:0]  ALUOp;
  logic [63:0] condAddr19Extended, brAddr26Extended;
  logic        negativeFlag, zeroFlag, overflowFlag, carryFlag;

  decode_control_unit dut (
    .clk                (clk),
    .reset              (reset),
    .instruction        (instruction),
    .zeroSignal         (zeroSignal),
    .negativeEX         (negativeEX),
    .zeroEX             (zeroEX),
    .overflowEX         (overflowEX),
    .carryEX            (carryEX),
    .setFlag_EX         (setFlag_EX),
    .Reg2Loc            (Reg2Loc),
    .ALUSrc             (ALUSrc),
    .MemToReg           (MemToReg),
    .RegWrite           (RegWrite),
    .MemWrite           (MemWrite),
    .BrTaken            (BrTaken),
    .UncondBr           (UncondBr),
    .UseShift           (UseShift),
    .shiftRight         (shiftRight),
    .setFlag            (setFlag),
    .ALUOp              (ALUOp),
    .condAddr19Extended (condAddr19Extended),
    .brAddr26Extended   (brAddr26Extended),
    .negativeFlag       (negativeFlag),
    .zeroFlag           (zeroFlag),
    .overflowFlag       (overflowFlag),
    .carryFlag          (carryFlag)
  );

  // Control word layout: {Reg2Loc, ALUSrc[1:0], MemToReg, RegWrite, MemWrite,
  //                       BrTaken, UncondBr, UseShift, shiftRight, setFlag, ALUOp[2:0]}
  typedef struct packed {
    logic [13:0] ctrl;
    logic [3:0]  flags;   // {N, Z, V, C}
    logic        chkExt;
    logic [63:0] cond;
    logic [63:0] br;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  event  chk;
  int    nChecks = 0;
  int    nFails  = 0;

  logic [13:0] w_actCtrl;
  logic [3:0]  w_actFlags;
  assign w_actCtrl  = {Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, BrTaken,
                       UncondBr, UseShift, shiftRight, setFlag, ALUOp};
  assign w_actFlags = {negativeFlag, zeroFlag, overflowFlag, carryFlag};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop the oldest expectation each time a vector is presented
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(chk);
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL scoreboard_underflow: got strobe, expected a queued entry");
      end else begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        nChecks++;
        if (w_actCtrl !== e.ctrl) begin
          nFails++;
          $display("FAIL %s ctrl: actual %b required %b", nm, w_actCtrl, e.ctrl);
        end
        nChecks++;
        if (w_actFlags !== e.flags) begin
          nFails++;
          $display("FAIL %s flags: actual %b required %b", nm, w_actFlags, e.flags);
        end
        if (e.chkExt) begin
          nChecks++;
          if (condAddr19Extended !== e.cond) begin
            nFails++;
            $display("FAIL %s cond19: actual %h required %h", nm, condAddr19Extended, e.cond);
          end
          nChecks++;
          if (brAddr26Extended !== e.br) begin
            nFails++;
            $display("FAIL %s br26: actual %h required %h", nm, brAddr26Extended, e.br);
          end
        end
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic z,
                       input logic [3:0] ex, input logic sf);
    instruction = ins;
    zeroSignal  = z;
    {negativeEX, zeroEX, overflowEX, carryEX} = ex;
    setFlag_EX  = sf;
  endtask

  task automatic expectVec(input string nm, input logic [13:0] c, input logic [3:0] f,
                           input logic ce, input logic [63:0] cd, input logic [63:0] b);
    exp_t e;
    #1;
    e.ctrl = c; e.flags = f; e.chkExt = ce; e.cond = cd; e.br = b;
    expQ.push_back(e);
    nameQ.push_back(nm);
    -> chk;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 1'b0, 4'b0000, 1'b0);

    // Reset state and all-zero instruction
    @(negedge clk);
    expectVec("reset_nop", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b0000, 1'b1, 64'h0, 64'h0);
    reset = 1'b0;

    @(negedge clk); drive(32'h91001401, 1'b0, 4'b0000, 1'b0);
    expectVec("addi", 14'b0_10_0_1_0_0_0_0_0_0_010, 4'b0000, 1'b1, 64'hA0, 64'h1001401);

    @(negedge clk); drive(32'h17FFFFFF, 1'b0, 4'b0000, 1'b0);
    expectVec("b_minus1", 14'b0_00_0_0_0_1_1_0_0_0_000, 4'b0000, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);

    @(negedge clk); drive(32'hB4000083, 1'b1, 4'b0000, 1'b0);
    expectVec("cbz_taken", 14'b0_00_0_0_0_1_0_0_0_0_000, 4'b0000, 1'b1, 64'h4, 64'h83);
    @(negedge clk); drive(32'hB4000083, 1'b0, 4'b0000, 1'b0);
    expectVec("cbz_not", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b0000, 1'b0, 64'h0, 64'h0);

    // B.LT forwarded from EX (N=1,V=0), register loads N,C on the next edge
    @(negedge clk); drive(32'h5400004B, 1'b0, 4'b1001, 1'b1);
    expectVec("blt_fwd", 14'b0_00_0_0_0_1_0_0_0_0_000, 4'b0000, 1'b1, 64'h2, 64'h4B);
    @(negedge clk); drive(32'h5400004B, 1'b0, 4'b0000, 1'b0);
    expectVec("blt_reg", 14'b0_00_0_0_0_1_0_0_0_0_000, 4'b1001, 1'b0, 64'h0, 64'h0);

    // Async reset mid-cycle with a pending load
    @(negedge clk); drive(32'h5400004B, 1'b0, 4'b1111, 1'b1);
    reset = 1'b1;
    expectVec("rst_async", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b0000, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    expectVec("rst_hold", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b0000, 1'b0, 64'h0, 64'h0);
    drive(32'hAB000000, 1'b0, 4'b1111, 1'b1);
    expectVec("rst_adds", 14'b1_00_0_0_0_0_0_0_0_0_010, 4'b0000, 1'b0, 64'h0, 64'h0);
    drive(32'hF8000000, 1'b0, 4'b1111, 1'b1);
    expectVec("rst_stur", 14'b0_01_0_0_0_0_0_0_0_0_010, 4'b0000, 1'b0, 64'h0, 64'h0);
    drive(32'h17FFFFFF, 1'b0, 4'b1111, 1'b1);
    expectVec("rst_b", 14'b0_00_0_0_0_0_1_0_0_0_000, 4'b0000, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(32'h5400004B, 1'b0, 4'b0000, 1'b0);
    @(negedge clk); reset = 1'b0;
    expectVec("blt_after_rst", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b0000, 1'b0, 64'h0, 64'h0);

    // Load N=1,Z=1,V=1: LT false both forwarded and registered
    @(negedge clk); drive(32'h5400004B, 1'b0, 4'b1110, 1'b1);
    expectVec("blt_nv_fwd", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b0000, 1'b0, 64'h0, 64'h0);
    @(negedge clk); drive(32'h5400004B, 1'b0, 4'b0000, 1'b0);
    expectVec("blt_nv_reg", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b1110, 1'b0, 64'h0, 64'h0);

    // Load V only: forwarded value differs from the old register
    @(negedge clk); drive(32'h5400004B, 1'b0, 4'b0010, 1'b1);
    expectVec("blt_v_fwd", 14'b0_00_0_0_0_1_0_0_0_0_000, 4'b1110, 1'b0, 64'h0, 64'h0);
    @(negedge clk); drive(32'h5400004B, 1'b0, 4'b0000, 1'b0);
    expectVec("blt_v_reg", 14'b0_00_0_0_0_1_0_0_0_0_000, 4'b0010, 1'b0, 64'h0, 64'h0);
    @(negedge clk); drive(32'h5400004A, 1'b0, 4'b0000, 1'b0);
    expectVec("bge_nop", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b0010, 1'b0, 64'h0, 64'h0);

    // Remaining instruction classes (flag register holds 0010)
    @(negedge clk); drive(32'hF8000000, 1'b0, 4'b0000, 1'b0);
    expectVec("stur", 14'b0_01_0_0_1_0_0_0_0_0_010, 4'b0010, 1'b1, 64'h0, 64'h0);
    drive(32'hF8400000, 1'b0, 4'b0000, 1'b0);
    expectVec("ldur", 14'b0_01_1_1_0_0_0_0_0_0_010, 4'b0010, 1'b0, 64'h0, 64'h0);
    drive(32'hAB000000, 1'b0, 4'b0000, 1'b0);
    expectVec("adds", 14'b1_00_0_1_0_0_0_0_0_1_010, 4'b0010, 1'b0, 64'h0, 64'h0);
    drive(32'hEB000000, 1'b0, 4'b0000, 1'b0);
    expectVec("subs", 14'b1_00_0_1_0_0_0_0_0_1_011, 4'b0010, 1'b0, 64'h0, 64'h0);
    drive(32'h8A000000, 1'b0, 4'b0000, 1'b0);
    expectVec("and", 14'b1_00_0_1_0_0_0_0_0_0_100, 4'b0010, 1'b0, 64'h0, 64'h0);
    drive(32'hCA000000, 1'b0, 4'b0000, 1'b0);
    expectVec("eor", 14'b1_00_0_1_0_0_0_0_0_0_110, 4'b0010, 1'b0, 64'h0, 64'h0);
    drive(32'hD3400000, 1'b0, 4'b0000, 1'b0);
    expectVec("lsr", 14'b0_00_0_1_0_0_0_1_1_0_000, 4'b0010, 1'b0, 64'h0, 64'h0);
    drive(32'hD3600000, 1'b0, 4'b0000, 1'b0);
    expectVec("lsl", 14'b0_00_0_1_0_0_0_1_0_0_000, 4'b0010, 1'b0, 64'h0, 64'h0);
    drive(32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0);
    expectVec("undecoded", 14'b0_00_0_0_0_0_0_0_0_0_000, 4'b0010, 1'b0, 64'h0, 64'h0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
